// File: rtl/turn_signal_fsm.sv
// Thunderbird-style turn-signal controller.
//
// Left, right and hazard switches are debounced independently. The debounced
// levels select a mode (IDLE/LEFT/RIGHT/HAZARD) and each mode steps a lamp
// pattern once every TICK_DIV clock cycles.
//
// Parameters:
//   LAMPS           lamps per side (1..8)
//   TICK_DIV        clock cycles per pattern step (>=1)
//   DEBOUNCE_CYCLES consecutive differing samples needed to accept a new level (>=1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   left_sw    raw left switch
//   right_sw   raw right switch
//   hazard_sw  raw hazard switch
//   la         left lamps, bit0 innermost
//   ra         right lamps, bit0 innermost
//   mode       current state: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD
module turn_signal_fsm #(
    parameter int LAMPS           = 3,
    parameter int TICK_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left_sw,
    input  logic             right_sw,
    input  logic             hazard_sw,
    output logic [LAMPS-1:0] la,
    output logic [LAMPS-1:0] ra,
    output logic [1:0]       mode
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(LAMPS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } state_t;

    state_t          state, state_nxt, req;
    logic [2:0]      raw;
    logic [2:0]      db, db_nxt;
    logic [CW-1:0]   cnt     [3];
    logic [CW-1:0]   cnt_nxt [3];
    logic [SW-1:0]   step, step_nxt;
    logic [TW-1:0]   tick, tick_nxt;
    logic [LAMPS-1:0] fill;

    // index 0 = left, 1 = right, 2 = hazard
    assign raw = {hazard_sw, right_sw, left_sw};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
            tick  <= '0;
            db    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            tick  <= tick_nxt;
            db    <= db_nxt;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Debounce: the count completes on the DEBOUNCE_CYCLES-th consecutive
    // differing sample, so the level is taken when the old count is one short.
    always_comb begin
        db_nxt = db;
        for (int unsigned i = 0; i < 3; i++) begin
            cnt_nxt[i] = '0;
            if (raw[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i] = raw[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (db[2] || (db[0] && db[1])) begin
            req = HAZARD;
        end else if (db[0]) begin
            req = LEFT;
        end else if (db[1]) begin
            req = RIGHT;
        end else begin
            req = IDLE;
        end
    end

    // A mode change wins over a pending step advance so the new pattern
    // always restarts from all-off.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        tick_nxt  = tick;
        if (req != state) begin
            state_nxt = req;
            step_nxt  = '0;
            tick_nxt  = '0;
        end else if (state == IDLE) begin
            step_nxt = '0;
            tick_nxt = '0;
        end else if (tick == TICK_LAST) begin
            tick_nxt = '0;
            if (state == HAZARD) begin
                step_nxt = (step == '0) ? SW'(1) : '0;
            end else begin
                step_nxt = (step == STEP_LAST) ? '0 : step + 1'b1;
            end
        end else begin
            tick_nxt = tick + 1'b1;
        end
    end

    // Fill pattern (1<<step)-1: lamp i lit when i < step.
    always_comb begin
        fill = '0;
        for (int unsigned i = 0; i < LAMPS; i++) begin
            fill[i] = (i < 32'(step));
        end
    end

    always_comb begin
        la = '0;
        ra = '0;
        case (state)
            LEFT:    la = fill;
            RIGHT:   ra = fill;
            HAZARD: begin
                la = {LAMPS{step[0]}};
                ra = {LAMPS{step[0]}};
            end
            default: ;
        endcase
    end

    assign mode = state;

endmodule

// File: tb/tb_turn_signal_fsm.sv
module tb_turn_signal_fsm;

    localparam int L  = 3;
    localparam int TD = 4;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       left_sw = 1'b0, right_sw = 1'b0, hazard_sw = 1'b0;
    logic [2:0] la, ra;
    logic [1:0] mode;

    logic       p_left = 1'b0, p_right = 1'b0, p_hazard = 1'b0;
    logic [4:0] p_la, p_ra;
    logic [1:0] p_mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turn_signal_fsm #(.LAMPS(L), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .left_sw(left_sw), .right_sw(right_sw),
        .hazard_sw(hazard_sw), .la(la), .ra(ra), .mode(mode)
    );

    turn_signal_fsm #(.LAMPS(5), .TICK_DIV(1), .DEBOUNCE_CYCLES(1)) pdut (
        .clk(clk), .reset(reset), .left_sw(p_left), .right_sw(p_right),
        .hazard_sw(p_hazard), .la(p_la), .ra(p_ra), .mode(p_mode)
    );

    // Reference model: integer counters driven straight from the rules.
    int m_db[3], m_cnt[3];
    int m_mode = 0, m_tick = 0, m_step = 0;

    task automatic model_edge();
        int raw[3];
        int req;
        raw[0] = left_sw ? 1 : 0;
        raw[1] = right_sw ? 1 : 0;
        raw[2] = hazard_sw ? 1 : 0;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_db[i] = 0;
                m_cnt[i] = 0;
            end
            m_mode = 0; m_tick = 0; m_step = 0;
            return;
        end
        if (m_db[2] == 1 || (m_db[0] == 1 && m_db[1] == 1)) req = 3;
        else if (m_db[0] == 1) req = 1;
        else if (m_db[1] == 1) req = 2;
        else req = 0;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] == m_db[i]) m_cnt[i] = 0;
            else begin
                m_cnt[i]++;
                if (m_cnt[i] == DC) begin
                    m_db[i] = raw[i];
                    m_cnt[i] = 0;
                end
            end
        end
        if (req != m_mode) begin
            m_mode = req; m_tick = 0; m_step = 0;
        end else if (m_mode != 0) begin
            m_tick++;
            if (m_tick == TD) begin
                m_tick = 0;
                if (m_mode == 3) m_step = 1 - m_step;
                else m_step = (m_step + 1) % (L + 1);
            end
        end
    endtask

    function automatic int exp_side(int side_mode);
        if (m_mode == side_mode) return (1 << m_step) - 1;
        if (m_mode == 3) return (m_step == 1) ? (1 << L) - 1 : 0;
        return 0;
    endfunction

    task automatic tick_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_sw(logic [2:0] sw);
        left_sw = sw[2]; right_sw = sw[1]; hazard_sw = sw[0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_sw(3'b000);
        p_right = 1'b0;
        tick_edge();
        tick_edge();
        reset = 1'b0;
    endtask

    typedef struct {
        bit         start;
        logic [2:0] sw;      // {left, right, hazard}
        int         edge_n;
        logic [2:0] la;
        logic [2:0] ra;
        logic [1:0] mode;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit s, logic [2:0] sw, int e, logic [2:0] a,
                                logic [2:0] b, logic [1:0] m);
        vec_t v;
        v.start = s; v.sw = sw; v.edge_n = e; v.la = a; v.ra = b; v.mode = m;
        return v;
    endfunction

    initial begin
        int e;
        // left fill
        vecs.push_back(mk(1, 3'b100,  2, 3'd0, 3'd0, 2'd0));
        vecs.push_back(mk(0, 3'b100,  3, 3'd0, 3'd0, 2'd1));
        vecs.push_back(mk(0, 3'b100,  6, 3'd0, 3'd0, 2'd1));
        vecs.push_back(mk(0, 3'b100,  7, 3'd1, 3'd0, 2'd1));
        vecs.push_back(mk(0, 3'b100, 11, 3'd3, 3'd0, 2'd1));
        vecs.push_back(mk(0, 3'b100, 15, 3'd7, 3'd0, 2'd1));
        vecs.push_back(mk(0, 3'b100, 19, 3'd0, 3'd0, 2'd1));
        vecs.push_back(mk(0, 3'b100, 23, 3'd1, 3'd0, 2'd1));
        // hazard via left+right
        vecs.push_back(mk(1, 3'b110,  3, 3'd0, 3'd0, 2'd3));
        vecs.push_back(mk(0, 3'b110,  7, 3'd7, 3'd7, 2'd3));
        vecs.push_back(mk(0, 3'b110, 11, 3'd0, 3'd0, 2'd3));
        vecs.push_back(mk(0, 3'b110, 15, 3'd7, 3'd7, 2'd3));
        // hazard switch alone
        vecs.push_back(mk(1, 3'b001,  3, 3'd0, 3'd0, 2'd3));
        vecs.push_back(mk(0, 3'b001,  7, 3'd7, 3'd7, 2'd3));
        vecs.push_back(mk(0, 3'b001, 11, 3'd0, 3'd0, 2'd3));
        vecs.push_back(mk(0, 3'b001, 15, 3'd7, 3'd7, 2'd3));
        // right fill
        vecs.push_back(mk(1, 3'b010,  3, 3'd0, 3'd0, 2'd2));
        vecs.push_back(mk(0, 3'b010,  7, 3'd0, 3'd1, 2'd2));
        vecs.push_back(mk(0, 3'b010, 15, 3'd0, 3'd7, 2'd2));

        // reset with all switches high
        reset = 1'b1;
        set_sw(3'b111);
        for (int i = 0; i < 2; i++) begin
            tick_edge();
            chk("rst_la", 8'(la), 8'd0);
            chk("rst_ra", 8'(ra), 8'd0);
            chk("rst_mode", 8'(mode), 8'd0);
        end
        reset = 1'b0;
        tick_edge();
        chk("rst_rel_la", 8'(la), 8'd0);
        chk("rst_rel_ra", 8'(ra), 8'd0);
        chk("rst_rel_mode", 8'(mode), 8'd0);

        // table-driven vectors
        e = -1;
        foreach (vecs[k]) begin
            if (vecs[k].start) begin
                do_reset();
                set_sw(vecs[k].sw);
                e = -1;
            end
            while (e < vecs[k].edge_n) begin
                tick_edge();
                e++;
            end
            chk($sformatf("vec%0d_la", k), 8'(la), 8'(vecs[k].la));
            chk($sformatf("vec%0d_ra", k), 8'(ra), 8'(vecs[k].ra));
            chk($sformatf("vec%0d_mode", k), 8'(mode), 8'(vecs[k].mode));
        end

        // glitch rejection: two high samples then low
        do_reset();
        set_sw(3'b100);
        tick_edge();
        tick_edge();
        set_sw(3'b000);
        for (int i = 0; i < 10; i++) begin
            tick_edge();
            chk("glitch_mode", 8'(mode), 8'd0);
            chk("glitch_la", 8'(la), 8'd0);
        end

        // mid-sequence switch from LEFT to RIGHT
        do_reset();
        set_sw(3'b100);
        for (int i = 0; i <= 11; i++) tick_edge();
        chk("mid_la011", 8'(la), 8'd3);
        set_sw(3'b010);
        for (int i = 12; i <= 14; i++) tick_edge();
        chk("mid_still_left", 8'(mode), 8'd1);
        tick_edge();
        chk("mid_mode", 8'(mode), 8'd2);
        chk("mid_la", 8'(la), 8'd0);
        chk("mid_ra0", 8'(ra), 8'd0);
        for (int i = 16; i <= 18; i++) tick_edge();
        chk("mid_ra_hold", 8'(ra), 8'd0);
        tick_edge();
        chk("mid_ra1", 8'(ra), 8'd1);

        // reset mid-hazard
        do_reset();
        set_sw(3'b001);
        for (int i = 0; i <= 7; i++) tick_edge();
        chk("hz_on", 8'(la), 8'd7);
        reset = 1'b1;
        tick_edge();
        chk("hzrst_la", 8'(la), 8'd0);
        chk("hzrst_ra", 8'(ra), 8'd0);
        chk("hzrst_mode", 8'(mode), 8'd0);
        reset = 1'b0;

        // LAMPS=5, TICK_DIV=1, DEBOUNCE_CYCLES=1
        do_reset();
        p_right = 1'b1;
        begin
            logic [4:0] pexp [8];
            pexp = '{5'd0, 5'd0, 5'd1, 5'd3, 5'd7, 5'd15, 5'd31, 5'd0};
            for (int i = 0; i < 8; i++) begin
                tick_edge();
                chk($sformatf("param_ra_e%0d", i), 8'(p_ra), 8'(pexp[i]));
                chk($sformatf("param_la_e%0d", i), 8'(p_la), 8'd0);
            end
            chk("param_mode", 8'(p_mode), 8'd2);
        end
        p_right = 1'b0;

        // randomized stimulus against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                logic [2:0] r;
                r = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) r[0] = 1'b0;
                set_sw(r);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick_edge();
            chk("rand_mode", 8'(mode), 8'(m_mode));
            chk("rand_la", 8'(la), 8'(exp_side(1)));
            chk("rand_ra", 8'(ra), 8'(exp_side(2)));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
